// File: rtl/ddr_wr_packer.sv
// ddr_wr_packer: packs RGB565 pixels into DDR words, queues {addr,data} in a small FIFO and
// issues single-beat writes over wr_req/wr_busy/wr_done. Define DDR_WR_DOUBLE_BUF_EN for double buffering.
module ddr_wr_packer #(
    parameter int unsigned       PIX_W       = 16,
    parameter int unsigned       WORD_W      = 256,
    parameter int unsigned       ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] FRAME_BASE  = '0,
    parameter int unsigned       FRAME_WORDS = 129600,
    parameter int unsigned       ADDR_STEP   = 8,
    parameter int unsigned       FIFO_DEPTH  = 4
) (
    input  logic              ddr_clk,
    input  logic              rstn,
    input  logic              init_done,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_busy,
    input  logic              wr_done,
    output logic              overflow,
    output logic              frame_done,
    output logic              rd_frame_sel
);
    localparam int unsigned SLOTS = WORD_W / PIX_W;
    localparam int unsigned PC_W  = $clog2(SLOTS);
    localparam int unsigned WC_W  = $clog2(FRAME_WORDS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_pack;
    logic [PC_W-1:0]   r_pack_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [WORD_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;

    logic              w_pix_acc;
    logic              w_word_done;
    logic              w_last;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [PTR_W-1:0]  w_widx;
    logic [PTR_W-1:0]  w_ridx;
    logic [WORD_W-1:0] w_word;
    logic [ADDR_W-1:0] w_base_next;

    assign w_widx  = r_wptr[PTR_W-1:0];
    assign w_ridx  = r_rptr[PTR_W-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) && (w_widx == w_ridx);

    // Once the frame's word budget is used up, pixels are ignored until the next frame_start.
    assign w_pix_acc   = pix_valid && init_done &&
                         (frame_start || (r_word_cnt < WC_W'(FRAME_WORDS)));
    assign w_word_done = w_pix_acc && !frame_start && (r_pack_cnt == PC_W'(SLOTS - 1));
    assign w_last      = (r_word_cnt == WC_W'(FRAME_WORDS - 1));
    assign w_pop       = ((r_state == S_REQ) && wr_busy && wr_done) ||
                         ((r_state == S_WAIT) && wr_done);
    assign w_push      = w_word_done && (!w_full || w_pop);
    assign w_drop      = w_word_done && w_full && !w_pop;

    always_comb begin
        w_word = r_pack;
        w_word[WORD_W-1 -: PIX_W] = pix_data;
    end

`ifdef DDR_WR_DOUBLE_BUF_EN
    localparam logic [ADDR_W-1:0] BASE1 = FRAME_BASE + ADDR_W'(FRAME_WORDS * ADDR_STEP);

    logic                  r_wbuf;
    logic                  r_started;
    logic                  w_buf_next;
    logic [FIFO_DEPTH-1:0] r_fifo_buf;

    // The first frame after reset lands in buffer 0; every later frame_start flips buffers.
    assign w_buf_next  = r_started ? ~r_wbuf : r_wbuf;
    assign w_base_next = w_buf_next ? BASE1 : FRAME_BASE;

    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            r_wbuf    <= 1'b0;
            r_started <= 1'b0;
        end else if (frame_start) begin
            r_wbuf    <= w_buf_next;
            r_started <= 1'b1;
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (w_push) begin
            r_fifo_buf[w_widx] <= r_wbuf;
        end
    end

    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            rd_frame_sel <= 1'b0;
        end else if (w_pop && r_fifo_last[w_ridx]) begin
            rd_frame_sel <= r_fifo_buf[w_ridx];
        end
    end
`else
    assign w_base_next  = FRAME_BASE;
    assign rd_frame_sel = 1'b0;
`endif

    // Pixel packing, frame address generation and sticky overflow.
    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            r_pack     <= '0;
            r_pack_cnt <= '0;
            r_word_cnt <= '0;
            r_cur_addr <= FRAME_BASE;
            overflow   <= 1'b0;
        end else if (frame_start) begin
            r_word_cnt <= '0;
            r_cur_addr <= w_base_next;
            overflow   <= 1'b0;
            if (w_pix_acc) begin
                r_pack[PIX_W-1:0] <= pix_data;
                r_pack_cnt        <= PC_W'(1);
            end else begin
                r_pack_cnt <= '0;
            end
        end else if (w_pix_acc) begin
            r_pack[32'(r_pack_cnt) * PIX_W +: PIX_W] <= pix_data;
            r_pack_cnt <= r_pack_cnt + PC_W'(1);
            if (w_word_done) begin
                r_cur_addr <= r_cur_addr + ADDR_W'(ADDR_STEP);
                r_word_cnt <= r_word_cnt + WC_W'(1);
                if (w_drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (w_push) begin
            r_fifo_addr[w_widx] <= r_cur_addr;
            r_fifo_data[w_widx] <= w_word;
            r_fifo_last[w_widx] <= w_last;
        end
    end

    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
        end
    end

    // Write FSM: the head entry stays in the FIFO until its wr_done.
    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_pop && r_fifo_last[w_ridx];
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        wr_addr <= r_fifo_addr[w_ridx];
                        wr_data <= r_fifo_data[w_ridx];
                        wr_req  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (wr_busy) begin
                        wr_req  <= 1'b0;
                        r_state <= wr_done ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wr_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    wr_req  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Scoreboard bench for ddr_wr_packer: a full-size instance (A) and a FRAME_WORDS=2 instance (B).
module tb_ddr_wr_packer;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned WORD_W = 256;
    localparam int unsigned FW_A   = 129600;
    localparam int unsigned FW_B   = 2;
`ifdef DDR_WR_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn, init_done, frame_start, pix_valid;
    logic [15:0] pix_data;
    logic en_a, en_b;
    logic fs_a, fs_b, pv_a, pv_b;

    logic              wr_req_a, wr_busy_a, wr_done_a, ovf_a, fd_a, sel_a;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [WORD_W-1:0] wr_data_a;
    logic              wr_req_b, wr_busy_b, wr_done_b, ovf_b, fd_b, sel_b;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [WORD_W-1:0] wr_data_b;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [27:0] ea_a, ea_b;
    bit          buf_a, buf_b, st_a, st_b;
    bit          stall_a, act_a, act_b;
    logic        prev_a, prev_b;
    int          n_vec, n_err;
    int          n_done_b, n_fd_b, n_fd_a, writes_b;

    always #5 clk = ~clk;

    assign fs_a = frame_start & en_a;
    assign pv_a = pix_valid & en_a;
    assign fs_b = frame_start & en_b;
    assign pv_b = pix_valid & en_b;

    ddr_wr_packer dut_a (
        .ddr_clk(clk), .rstn(rstn), .init_done(init_done), .frame_start(fs_a),
        .pix_valid(pv_a), .pix_data(pix_data), .wr_req(wr_req_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .wr_busy(wr_busy_a), .wr_done(wr_done_a), .overflow(ovf_a),
        .frame_done(fd_a), .rd_frame_sel(sel_a)
    );

    ddr_wr_packer #(.FRAME_WORDS(FW_B)) dut_b (
        .ddr_clk(clk), .rstn(rstn), .init_done(init_done), .frame_start(fs_b),
        .pix_valid(pv_b), .pix_data(pix_data), .wr_req(wr_req_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .wr_busy(wr_busy_b), .wr_done(wr_done_b), .overflow(ovf_b),
        .frame_done(fd_b), .rd_frame_sel(sel_b)
    );

    function automatic void chk(input string nm, input logic [WORD_W-1:0] act,
                                input logic [WORD_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Buffer/address model: first frame after reset uses buffer 0, later frames alternate.
    task automatic fs_model();
        if (en_b) begin
            if (st_b) buf_b = ~buf_b;
            st_b     = 1'b1;
            ea_b     = (DBL && buf_b) ? 28'(FW_B * 8) : 28'h0;
            n_done_b = 0;
        end else begin
            if (st_a) buf_a = ~buf_a;
            st_a = 1'b1;
            ea_a = (DBL && buf_a) ? 28'(FW_A * 8) : 28'h0;
        end
    endtask

    task automatic fstart();
        fs_model();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pix(input logic [15:0] v);
        pix_valid = 1'b1;
        pix_data  = v;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    // Sends 16 consecutive pixels starting at 'first'; keep=0 means the word is expected to be dropped.
    task automatic send_word(input logic [15:0] first, input bit keep, input bit with_fs);
        exp_t e;
        if (with_fs) fs_model();
        e.addr = en_b ? ea_b : ea_a;
        for (int i = 0; i < 16; i++) e.data[16*i +: 16] = first + 16'(i);
        if (keep) begin
            if (en_b) qb.push_back(e);
            else      qa.push_back(e);
        end
        if (en_b) ea_b += 28'd8;
        else      ea_a += 28'd8;
        for (int i = 0; i < 16; i++) begin
            frame_start = with_fs && (i == 0);
            pix(first + 16'(i));
        end
        frame_start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || act_a || act_b || wr_req_a || wr_req_b)
               && t < 600) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 600) begin
            n_err++;
            $display("FAIL drain_timeout: qa=%0d qb=%0d after %0d cycles", qa.size(), qb.size(), t);
        end
        repeat (4) @(negedge clk);
    endtask

    // Responder A: wr_busy 2 cycles after wr_req, wr_done 3 cycles after wr_busy.
    initial begin : resp_a
        wr_busy_a = 1'b0;
        wr_done_a = 1'b0;
        act_a     = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_req_a && !stall_a) begin
                act_a = 1'b1;
                @(negedge clk); wr_busy_a = 1'b1;
                @(negedge clk); wr_busy_a = 1'b0;
                chk("req_drop_a", wr_req_a, 0);
                @(negedge clk);
                @(negedge clk); wr_done_a = 1'b1;
                @(negedge clk); wr_done_a = 1'b0;
                act_a = 1'b0;
            end
        end
    end

    // Responder B: wr_busy and wr_done together in the same cycle.
    initial begin : resp_b
        wr_busy_b = 1'b0;
        wr_done_b = 1'b0;
        act_b     = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_req_b) begin
                act_b     = 1'b1;
                wr_busy_b = 1'b1;
                wr_done_b = 1'b1;
                n_done_b++;
                @(negedge clk);
                wr_busy_b = 1'b0;
                wr_done_b = 1'b0;
                chk("req_drop_b", wr_req_b, 0);
                act_b = 1'b0;
            end
        end
    end

    // Monitors: pop the expected word on each new request.
    always @(negedge clk) begin
        if (rstn) begin
            if (wr_req_a && !prev_a) begin
                if (qa.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_wr_a: addr %0h with no expected word", wr_addr_a);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("wr_addr_a", 256'(wr_addr_a), 256'(e.addr));
                    chk("wr_data_a", wr_data_a, e.data);
                end
            end
            if (wr_req_b && !prev_b) begin
                writes_b <= writes_b + 1;
                if (qb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_wr_b: addr %0h with no expected word", wr_addr_b);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("wr_addr_b", 256'(wr_addr_b), 256'(e.addr));
                    chk("wr_data_b", wr_data_b, e.data);
                end
            end
            if (fd_b) begin
                n_fd_b <= n_fd_b + 1;
                chk("fd_on_2nd_done_b", 256'(n_done_b), 256'(2));
            end
            if (fd_a) n_fd_a <= n_fd_a + 1;
        end
        prev_a <= wr_req_a;
        prev_b <= wr_req_b;
    end

    initial begin : main
        rstn = 1'b0; init_done = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        en_a = 1'b1; en_b = 1'b0; stall_a = 1'b0;
        ea_a = '0; ea_b = '0; buf_a = 0; buf_b = 0; st_a = 0; st_b = 0;
        n_vec = 0; n_err = 0; n_done_b = 0; n_fd_b = 0; n_fd_a = 0; writes_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_wr_req", 256'({wr_req_a, wr_req_b}), 0);
        chk("rst_wr_addr", 256'({wr_addr_a, wr_addr_b}), 0);
        chk("rst_wr_data_a", wr_data_a, 0);
        chk("rst_wr_data_b", wr_data_b, 0);
        chk("rst_flags", 256'({ovf_a, fd_a, sel_a, ovf_b, fd_b, sel_b}), 0);
        rstn = 1'b1;
        @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);

        // single word, pixels 0..F
        fstart();
        send_word(16'h0000, 1'b1, 1'b0);
        drain();
        chk("t1_wr_addr", 256'(wr_addr_a), 0);
        chk("t1_pix0", 256'(wr_data_a[15:0]), 256'(16'h0000));
        chk("t1_pix15", 256'(wr_data_a[255:240]), 256'(16'h000F));

        // three back-to-back words
        fstart();
        for (int w = 0; w < 3; w++) send_word(16'h0100 + 16'(16 * w), 1'b1, 1'b0);
        drain();

        // FIFO overflow while the write side is stalled
        fstart();
        stall_a = 1'b1;
        for (int w = 0; w < 4; w++) send_word(16'h0300 + 16'(16 * w), 1'b1, 1'b0);
        chk("t3_ovf_before", 256'(ovf_a), 0);
        send_word(16'h0340, 1'b0, 1'b0);
        send_word(16'h0350, 1'b0, 1'b0);
        chk("t3_ovf_set", 256'(ovf_a), 1);
        fstart();
        chk("t3_ovf_clear", 256'(ovf_a), 0);
        stall_a = 1'b0;
        drain();

        // partial word discarded; frame_start with a pixel makes it slot 0
        fstart();
        for (int i = 0; i < 7; i++) pix(16'h0400 + 16'(i));
        send_word(16'h0500, 1'b1, 1'b1);
        drain();

        // pixels ignored while init_done is low
        init_done = 1'b0;
        for (int i = 0; i < 5; i++) pix(16'h0600 + 16'(i));
        init_done = 1'b1;
        send_word(16'h0700, 1'b1, 1'b0);
        drain();
        chk("t4_ovf", 256'(ovf_a), 0);

        // FRAME_WORDS=2: frame_done on second wr_done, extra pixels ignored
        en_a = 1'b0;
        en_b = 1'b1;
        fstart();
        send_word(16'h0800, 1'b1, 1'b0);
        send_word(16'h0810, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) pix(16'h0900 + 16'(i));
        drain();
        chk("t5_writes_b", 256'(writes_b), 2);
        chk("t5_fd_count", 256'(n_fd_b), 1);
        chk("t5_rd_sel", 256'(sel_b), 0);

        // second full frame goes to the other buffer
        fstart();
        send_word(16'h0A00, 1'b1, 1'b0);
        send_word(16'h0A10, 1'b1, 1'b0);
        drain();
        chk("t6_fd_count", 256'(n_fd_b), 2);
        chk("t6_rd_sel", 256'(sel_b), 256'(DBL));

        // aborted frame leaves rd_frame_sel alone
        fstart();
        send_word(16'h0B00, 1'b1, 1'b0);
        drain();
        fstart();
        repeat (4) @(negedge clk);
        chk("t6_abort_rd_sel", 256'(sel_b), 256'(DBL));
        chk("t6_abort_fd", 256'(n_fd_b), 2);
        chk("t6_writes_b", 256'(writes_b), 5);
        chk("a_no_frame_done", 256'(n_fd_a), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
